// File: rtl/dmem_if.sv
// dmem_if: W-stage decode, data-memory port and pipeline handshake bundle
interface dmem_if;
  logic        dmem_sel;
  logic [1:0]  w_sel;
  logic [2:0]  r_sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic [31:0] ld_data;
  logic        err_misalign;
  logic        err_timeout;
  modport slave (
    input  dmem_sel, w_sel, r_sel, addr, wdata, mem_rdata, mem_ack,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall, ld_data, err_misalign, err_timeout
  );
  modport master (
    output dmem_sel, w_sel, r_sel, addr, wdata, mem_rdata, mem_ack,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall, ld_data, err_misalign, err_timeout
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences W-stage loads/stores into req/ack memory transactions and stalls the pipeline
module dmem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t          state_q, state_d;
  logic            req_q, req_d, we_q, we_d, mis_q, mis_d, to_q, to_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d;
  logic [3:0]      be_q, be_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            op_valid, is_half, is_word, misaligned;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [31:0]     ld_ext, st_data;
  logic [3:0]      st_be;
  always_comb begin
    op_valid   = bus.dmem_sel ? bus.w_sel != 2'b11 : bus.r_sel inside {3'b000, 3'b010, 3'b011, 3'b100, 3'b101};
    is_half    = bus.dmem_sel ? bus.w_sel == 2'b01 : bus.r_sel inside {3'b010, 3'b101};
    is_word    = bus.dmem_sel ? bus.w_sel == 2'b10 : bus.r_sel == 3'b011;
    misaligned = (is_half & bus.addr[0]) | (is_word & |bus.addr[1:0]);
    byte_sel   = bus.mem_rdata[{bus.addr[1:0], 3'b000} +: 8];
    half_sel   = bus.addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    ld_ext     = bus.r_sel == 3'b000 ? {{24{byte_sel[7]}}, byte_sel} :
                 bus.r_sel == 3'b100 ? {24'h0, byte_sel} :
                 bus.r_sel == 3'b010 ? {{16{half_sel[15]}}, half_sel} :
                 bus.r_sel == 3'b101 ? {16'h0, half_sel} : bus.mem_rdata;
    st_be      = !bus.dmem_sel ? 4'b1111 :
                 bus.w_sel == 2'b00 ? 4'b0001 << bus.addr[1:0] :
                 bus.w_sel == 2'b01 ? (bus.addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    st_data    = !bus.dmem_sel ? 32'h0 :
                 bus.w_sel == 2'b00 ? {4{bus.wdata[7:0]}} :
                 bus.w_sel == 2'b01 ? {2{bus.wdata[15:0]}} : bus.wdata;
  end
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    ld_d    = ld_q;
    cnt_d   = cnt_q;
    mis_d   = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      IDLE: if (op_valid) begin
        if (misaligned) begin
          state_d = DONE;
          mis_d   = 1'b1;
        end else begin
          state_d = ACCESS;
          req_d   = 1'b1;
          we_d    = bus.dmem_sel;
          addr_d  = {bus.addr[31:2], 2'b00};
          be_d    = st_be;
          wdata_d = st_data;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        // ack wins over a timeout landing on the same cycle
        if (bus.mem_ack || cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          be_d    = '0;
          wdata_d = '0;
          to_d    = !bus.mem_ack;
          ld_d    = !bus.mem_ack ? 32'h0 : we_q ? ld_q : ld_ext;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.mem_req      = req_q;
  assign bus.mem_we       = we_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_be       = be_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.ld_data      = ld_q;
  assign bus.err_misalign = mis_q;
  assign bus.err_timeout  = to_q;
  assign bus.stall        = op_valid & (state_q != DONE);
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: table-driven load/store vectors with a scoreboard queue, plus reset and idle-ack sequences
module tb_dmem_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;
  dmem_if bus();
  dmem_access_ctrl #(.TIMEOUT(16), .TO_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic        ds;
    logic [1:0]  ws;
    logic [2:0]  rs;
    logic [31:0] addr, wdata, rdata;
    int          wait_n;
    logic        we;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] mwd, ld;
    logic        chk_ld, mis, to;
    int          stalls, reqs;
  } vec_t;
  vec_t vecs[15];
  vec_t sb[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic idle_inputs();
    bus.dmem_sel = 1'b0;
    bus.w_sel    = 2'b11;
    bus.r_sel    = 3'b111;
    bus.addr     = 32'h0;
    bus.wdata    = 32'h0;
  endtask
  task automatic do_op(input vec_t v);
    vec_t        e;
    int          stalls = 0;
    int          reqs = 0;
    logic        done = 1'b0;
    logic        c_we = 1'b0;
    logic [31:0] c_addr = 32'h0, c_wd = 32'h0;
    logic [3:0]  c_be = 4'h0;
    @(negedge clk);
    bus.dmem_sel = v.ds;
    bus.w_sel    = v.ws;
    bus.r_sel    = v.rs;
    bus.addr     = v.addr;
    bus.wdata    = v.wdata;
    sb.push_back(v);
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (!bus.stall) done = 1'b1;
      else begin
        stalls++;
        if (bus.mem_req) begin
          reqs++;
          if (reqs == 1) begin
            c_we = bus.mem_we; c_addr = bus.mem_addr; c_be = bus.mem_be; c_wd = bus.mem_wdata;
          end
          if (v.wait_n >= 0 && reqs == v.wait_n + 1) begin
            bus.mem_ack = 1'b1; bus.mem_rdata = v.rdata;
          end
        end
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        @(negedge clk);
      end
    end
    if (!done) chk("stall_bound", 32'(stalls), 32'(v.stalls));
    e = sb.pop_front();
    chk("stall_cycles", 32'(stalls), 32'(e.stalls));
    chk("req_cycles", 32'(reqs), 32'(e.reqs));
    chk("req_low_done", 32'(bus.mem_req), 32'h0);
    chk("err_misalign", 32'(bus.err_misalign), 32'(e.mis));
    chk("err_timeout", 32'(bus.err_timeout), 32'(e.to));
    if (e.reqs > 0) begin
      chk("mem_we", 32'(c_we), 32'(e.we));
      chk("mem_addr", c_addr, e.maddr);
      chk("mem_be", 32'(c_be), 32'(e.be));
      chk("mem_wdata", c_wd, e.mwd);
    end
    if (e.chk_ld) chk("ld_data", bus.ld_data, e.ld);
    @(posedge clk);
    #1;
    idle_inputs();
    chk("err_clear", {30'h0, bus.err_misalign, bus.err_timeout}, 32'h0);
  endtask
  initial begin
    //        ds    ws     rs      addr        wdata         rdata      wait we    maddr      be    mwd           ld          chk   mis   to  stl req
    vecs[0]  = '{1'b1, 2'b10, 3'b111, 32'h100, 32'hDEADBEEF, 32'h0,        0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0, 2, 1};
    vecs[1]  = '{1'b1, 2'b00, 3'b111, 32'h103, 32'h000000A5, 32'h0,        0, 1'b1, 32'h100, 4'h8, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0, 1'b0, 2, 1};
    vecs[2]  = '{1'b1, 2'b01, 3'b111, 32'h102, 32'h00001234, 32'h0,        0, 1'b1, 32'h100, 4'hC, 32'h12341234, 32'h0,        1'b0, 1'b0, 1'b0, 2, 1};
    vecs[3]  = '{1'b1, 2'b01, 3'b111, 32'h100, 32'hABCD1234, 32'h0,        0, 1'b1, 32'h100, 4'h3, 32'h12341234, 32'h0,        1'b0, 1'b0, 1'b0, 2, 1};
    vecs[4]  = '{1'b0, 2'b11, 3'b000, 32'h201, 32'h0,        32'h0000F000, 3, 1'b0, 32'h200, 4'hF, 32'h0,        32'hFFFFFFF0, 1'b1, 1'b0, 1'b0, 5, 4};
    vecs[5]  = '{1'b0, 2'b11, 3'b100, 32'h201, 32'h0,        32'h0000F000, 3, 1'b0, 32'h200, 4'hF, 32'h0,        32'h000000F0, 1'b1, 1'b0, 1'b0, 5, 4};
    vecs[6]  = '{1'b0, 2'b11, 3'b010, 32'h202, 32'h0,        32'h80010000, 1, 1'b0, 32'h200, 4'hF, 32'h0,        32'hFFFF8001, 1'b1, 1'b0, 1'b0, 3, 2};
    vecs[7]  = '{1'b0, 2'b11, 3'b101, 32'h202, 32'h0,        32'h80010000, 0, 1'b0, 32'h200, 4'hF, 32'h0,        32'h00008001, 1'b1, 1'b0, 1'b0, 2, 1};
    vecs[8]  = '{1'b0, 2'b11, 3'b011, 32'h206, 32'h0,        32'h0,        0, 1'b0, 32'h0,   4'h0, 32'h0,        32'h00008001, 1'b1, 1'b1, 1'b0, 1, 0};
    vecs[9]  = '{1'b1, 2'b10, 3'b111, 32'h101, 32'h11111111, 32'h0,        0, 1'b0, 32'h0,   4'h0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1, 0};
    vecs[10] = '{1'b1, 2'b01, 3'b111, 32'h103, 32'h22222222, 32'h0,        0, 1'b0, 32'h0,   4'h0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1, 0};
    vecs[11] = '{1'b1, 2'b00, 3'b111, 32'h102, 32'h0000005A, 32'h0,        0, 1'b1, 32'h100, 4'h4, 32'h5A5A5A5A, 32'h0,        1'b0, 1'b0, 1'b0, 2, 1};
    vecs[12] = '{1'b0, 2'b11, 3'b011, 32'h300, 32'h0,        32'h12345678, 2, 1'b0, 32'h300, 4'hF, 32'h0,        32'h12345678, 1'b1, 1'b0, 1'b0, 4, 3};
    vecs[13] = '{1'b0, 2'b11, 3'b000, 32'h200, 32'h0,        32'h0000007F, 0, 1'b0, 32'h200, 4'hF, 32'h0,        32'h0000007F, 1'b1, 1'b0, 1'b0, 2, 1};
    vecs[14] = '{1'b0, 2'b11, 3'b011, 32'h400, 32'h0,        32'h0,       -1, 1'b0, 32'h400, 4'hF, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 17, 16};
    idle_inputs();
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(bus.mem_req), 32'h0);
    chk("rst_be", 32'(bus.mem_be), 32'h0);
    chk("rst_ld", bus.ld_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    bus.dmem_sel = 1'b0; bus.r_sel = 3'b110;
    #1 chk("noop_load_stall", 32'(bus.stall), 32'h0);
    bus.dmem_sel = 1'b1; bus.w_sel = 2'b11;
    #1 chk("noop_store_stall", 32'(bus.stall), 32'h0);
    @(posedge clk);
    #1 chk("noop_req", 32'(bus.mem_req), 32'h0);
    idle_inputs();
    for (int i = 0; i < 15; i++) do_op(vecs[i]);
    @(negedge clk);
    bus.r_sel = 3'b011; bus.addr = 32'h500;
    @(posedge clk);
    #1 chk("mid_req_high", 32'(bus.mem_req), 32'h1);
    #2 rst = 1'b1;
    #1 chk("async_rst_req", 32'(bus.mem_req), 32'h0);
    chk("async_rst_be", 32'(bus.mem_be), 32'h0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1 bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    chk("idle_ack_req", 32'(bus.mem_req), 32'h0);
    chk("idle_ack_ld", bus.ld_data, 32'h0);
    chk("idle_ack_stall", 32'(bus.stall), 32'h0);
    do_op('{1'b0, 2'b11, 3'b011, 32'h500, 32'h0, 32'hCAFEF00D, 0, 1'b0, 32'h500, 4'hF, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 2, 1});
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequences the data-memory access for the instruction in the write-back stage. It turns the stage's dmem_sel/w_sel/r_sel decode into a multi-cycle req/ack transaction with byte enables, and stalls the pipeline until the transaction completes. It also returns the sign- or zero-extended load data to the write-back mux and flags misaligned or timed-out accesses. It sits between the W-stage control decode and the data memory port.

Parameters:
TIMEOUT, 16, max cycles in ACCESS without mem_ack before the access is aborted (range 1..2^TO_W-1)
TO_W, 5, width of the timeout counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
dmem_sel  in  1  1=store, 0=load/none (W-stage decode)
w_sel  in  2  store size: 00 byte, 01 half, 10 word, 11 none
r_sel  in  3  load type: 000 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 111 none (001/110 = none)
addr  in  32  byte address (ALU result)
wdata  in  32  store data (rs2)
mem_req  out  1  memory request, held until ack
mem_we  out  1  1=write
mem_addr  out  32  word address ({addr[31:2],2'b00})
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  read word, valid with mem_ack
mem_ack  in  1  1-cycle completion strobe
stall  out  1  freeze PC and all pipeline registers
ld_data  out  32  extended load result to WB mux
err_misalign  out  1  1-cycle pulse, misaligned access
err_timeout  out  1  1-cycle pulse, access aborted

Behaviour:
- Reset (async, immediate): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, ld_data=0, err_*=0, counter=0. Reset mid-transaction drops mem_req in the same instant, and no ack is consumed afterwards.
- op_valid = (dmem_sel & w_sel!=11) | (~dmem_sel & r_sel in {000,010,011,100,101}).
- misaligned = halfword op with addr[0]=1, or word op with addr[1:0]!=00. Byte ops are never misaligned.
- stall (combinational) = op_valid & state!=DONE.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, op_valid & misaligned -> DONE. err_misalign registers to 1, and no mem_req is issued.
- IDLE, op_valid & aligned -> ACCESS. On the same edge, register mem_addr, mem_we=dmem_sel, mem_be, mem_wdata, mem_req=1, counter=0.
- IDLE, !op_valid -> stay in IDLE, all outputs idle.
- ACCESS, mem_ack -> DONE. mem_req=0 on the same edge. For loads, ld_data gets the extended mem_rdata.
- ACCESS, no ack -> counter+1. When counter reaches TIMEOUT-1 without ack: mem_req=0, err_timeout=1, ld_data=0, -> DONE.
- DONE -> IDLE unconditionally. stall is low here, so the pipeline advances on this edge. err_* clear on leaving DONE. ld_data holds until the next load completes.
- Minimum latency: ack in the first ACCESS cycle gives stall high for 2 cycles, and the instruction retires in the 3rd.
- mem_ack seen in IDLE or DONE is ignored.
- Store byte enables:
  - SB: be = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - SW: be = 1111, wdata unchanged.
- Loads: mem_be=1111, mem_wdata=0.
- Load extension:
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; LW is the whole word.
  - LB/LH sign-extend; LBU/LHU zero-extend.

Test Plan:
- SW: addr=0x100, wdata=0xDEADBEEF, ack 1 cycle after req -> mem_addr=0x100, be=1111, mem_wdata=0xDEADBEEF, we=1; stall high exactly 2 cycles.
- SB: addr=0x103, wdata=0x000000A5 -> be=1000, mem_wdata=0xA5A5A5A5. Then SH: addr=0x102, wdata=0x1234 -> be=1100, mem_wdata=0x12341234.
- LB/LBU: addr=0x201, mem_rdata=0x0000F000, ack after 3 wait cycles -> LB ld_data=0xFFFFFFF0, LBU=0x000000F0; stall high 5 cycles.
- LH: addr=0x202, mem_rdata=0x80010000 -> ld_data=0xFFFF8001. LW: addr=0x206 -> err_misalign pulse, no mem_req, stall 1 cycle.
- Timeout: load issued with ack never asserted, TIMEOUT=16 -> mem_req high 16 cycles then low, err_timeout pulse, ld_data=0, pipeline resumes.
- Reset: assert rst during ACCESS -> mem_req=0 immediately, state IDLE. After release, an ack pulse is ignored and the next LW completes normally.
